pdm_modulator: RTL and testbench



---
 rtl/pdm_pkg.sv | 10 +
 rtl/pdm_sd_core.sv | 33 +++
 rtl/pdm_modulator.sv | 77 +++++++
 tb/tb_pdm_modulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared constants and types for the PDM modulator and the downstream PDM-to-duty recovery stage.
package pdm_pkg;

  localparam int DUTY_W     = 16;
  localparam int FRAME_BITS = 11;
  localparam int FRAME_LEN  = 2**FRAME_BITS;

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pdm_sd_core.sv
// First-order sigma-delta core: accumulates the active duty word and emits the carry as the PDM bit.
module pdm_sd_core #(
  parameter int DUTY_W = pdm_pkg::DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DUTY_W-1:0] duty_act,
  output logic              pdm
);

  logic [DUTY_W-1:0] accum;
  logic [DUTY_W:0]   sum;

  assign sum = {1'b0, accum} + {1'b0, duty_act};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum <= '0;
      pdm   <= 1'b0;
    end else if (!en) begin
      accum <= '0;
      pdm   <= 1'b0;
    end else begin
      // The clear cycle still emits the carry of the frame's last sum.
      pdm   <= sum[DUTY_W];
      accum <= clr ? '0 : sum[DUTY_W-1:0];
    end
  end

endmodule

// File: rtl/pdm_modulator.sv
// PDM modulator top: duty handshake, shadow register and frame counter around the sigma-delta core.
module pdm_modulator #(
  parameter int FRAME_BITS = pdm_pkg::FRAME_BITS,
  parameter int DUTY_W     = pdm_pkg::DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  input  logic              duty_vld,
  output logic              duty_rdy,
  output logic              PDM,
  output logic              frm_strt
);

  logic [DUTY_W-1:0]     shadow;
  logic [DUTY_W-1:0]     duty_act;
  logic                  pending;
  logic [FRAME_BITS-1:0] frm_cnt;
  logic                  wrap;
  logic                  accept;
  logic                  load;

  // NOTE: duty_rdy is combinational from pending so a transfer frees the slot for the very next cycle.
  assign duty_rdy = !pending;
  assign wrap     = &frm_cnt;
  assign accept   = duty_vld && duty_rdy;
  assign load     = en && wrap && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt  <= '1;
      frm_strt <= 1'b0;
    end else if (!en) begin
      // Parking on the last count makes the first enabled cycle a frame boundary.
      frm_cnt  <= '1;
      frm_strt <= 1'b0;
    end else if (wrap) begin
      frm_cnt  <= '0;
      frm_strt <= 1'b1;
    end else begin
      frm_cnt  <= frm_cnt + 1'b1;
      frm_strt <= 1'b0;
    end
  end

  // accept and load never coincide: accept needs pending low, load needs it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      pending  <= 1'b0;
      duty_act <= '0;
    end else begin
      if (accept) begin
        shadow  <= duty;
        pending <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
      if (load) begin
        duty_act <= shadow;
      end
    end
  end

  pdm_sd_core #(
    .DUTY_W (DUTY_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (wrap),
    .duty_act (duty_act),
    .pdm      (PDM)
  );

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: per-frame ones counts, handshake timing, enable and reset corners.
module tb_pdm_modulator;

  localparam int N = pdm_pkg::FRAME_LEN;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] duty;
  logic        duty_vld;
  logic        duty_rdy;
  logic        pdm;
  logic        frm_strt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [15:0] duty;
    int          ones;
    logic [15:0] rec;
    logic [3:0]  head;
  } vec_t;

  vec_t vecs[5];

  pdm_modulator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .duty     (duty),
    .duty_vld (duty_vld),
    .duty_rdy (duty_rdy),
    .PDM      (pdm),
    .frm_strt (frm_strt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    duty     = d;
    duty_vld = 1'b1;
    while (!duty_rdy && n < 3*N) begin
      step();
      n++;
    end
    if (!duty_rdy) check("send_rdy_timeout", 32'(duty_rdy), 32'd1);
    step();
    duty_vld = 1'b0;
  endtask

  task automatic wait_frm_strt();
    int n;
    n = 0;
    while (!frm_strt && n < 3*N) begin
      step();
      n++;
    end
    if (!frm_strt) check("frm_strt_timeout", 32'(frm_strt), 32'd1);
  endtask

  // Called in a frm_strt cycle: counts the N PDM bits of that frame and checks frm_strt spacing.
  task automatic count_frame(input string name, input int exp_ones, output logic [3:0] head);
    int ones;
    int strt_err;
    ones     = 0;
    strt_err = 0;
    head     = '0;
    for (int i = 0; i < N; i++) begin
      step();
      if (i == 0) duty_vld = 1'b0;
      ones += int'(pdm);
      if (i < 4) head[i] = pdm;
      if (frm_strt !== (i == N-1)) strt_err++;
    end
    check({name, "_ones"}, 32'(ones), 32'(exp_ones));
    check({name, "_strt"}, 32'(strt_err), 32'd0);
  endtask

  initial begin
    logic [3:0]  head;
    logic [15:0] rec;
    int          ones;
    int          bad;
    int          n;

    vecs[0] = '{duty: 16'h8000, ones: 1024, rec: 16'h8000, head: 4'b1010};
    vecs[1] = '{duty: 16'h0000, ones: 0,    rec: 16'h0000, head: 4'b0000};
    vecs[2] = '{duty: 16'h0020, ones: 1,    rec: 16'h0020, head: 4'b0000};
    vecs[3] = '{duty: 16'h1234, ones: 145,  rec: 16'h1220, head: 4'b0000};
    vecs[4] = '{duty: 16'hFFFF, ones: 2047, rec: 16'hFFE0, head: 4'b1110};

    rst_n    = 1'b0;
    en       = 1'b0;
    duty     = '0;
    duty_vld = 1'b0;
    #12;
    check("reset_rdy", 32'(duty_rdy), 32'd1);
    check("reset_pdm", 32'(pdm), 32'd0);
    check("reset_strt", 32'(frm_strt), 32'd0);

    // Idle: no duty ever sent.
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    check("first_wrap_strt", 32'(frm_strt), 32'd1);
    count_frame("idle_frame0", 0, head);
    count_frame("idle_frame1", 0, head);
    check("idle_rdy", 32'(duty_rdy), 32'd1);

    // Duty sweep, one word per frame.
    foreach (vecs[k]) begin
      send(vecs[k].duty);
      wait_frm_strt();
      count_frame($sformatf("sweep_%04h", vecs[k].duty), vecs[k].ones, head);
      check($sformatf("sweep_%04h_head", vecs[k].duty), 32'(head), 32'(vecs[k].head));
      ones = 0;
      for (int i = 0; i < 4; i++) ones += int'(head[i]);
      rec = 16'(vecs[k].ones * 32);
      check($sformatf("sweep_%04h_recovered", vecs[k].duty), 32'(rec), 32'(vecs[k].rec));
    end

    // Accept 0x2000, then hold 0x1000 on vld until the slot frees at the wrap.
    send(16'h2000);
    duty     = 16'h1000;
    duty_vld = 1'b1;
    bad = 0;
    n   = 0;
    while (!frm_strt && n < 3*N) begin
      if (duty_rdy) bad++;
      step();
      n++;
    end
    check("hold_rdy_low", 32'(bad), 32'd0);
    check("hold_wrap_seen", 32'(frm_strt), 32'd1);
    check("hold_rdy_after_wrap", 32'(duty_rdy), 32'd1);
    count_frame("hold_first", 256, head);
    count_frame("hold_second", 128, head);

    // vld exactly on the wrap cycle with nothing pending.
    run_cycles(N-1);
    duty     = 16'h0800;
    duty_vld = 1'b1;
    check("wrapvld_rdy", 32'(duty_rdy), 32'd1);
    step();
    duty_vld = 1'b0;
    check("wrapvld_strt", 32'(frm_strt), 32'd1);
    check("wrapvld_pending", 32'(duty_rdy), 32'd0);
    count_frame("wrapvld_same", 128, head);
    count_frame("wrapvld_next", 64, head);

    // Disable mid-frame with 0x4000 pending.
    send(16'h4000);
    run_cycles(500);
    en  = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pdm !== 1'b0 || frm_strt !== 1'b0) bad++;
    end
    check("dis_quiet", 32'(bad), 32'd0);
    check("dis_rdy_pending", 32'(duty_rdy), 32'd0);
    en = 1'b1;
    step();
    check("reen_strt", 32'(frm_strt), 32'd1);
    check("reen_pdm", 32'(pdm), 32'd0);
    check("reen_rdy", 32'(duty_rdy), 32'd1);
    count_frame("reen", 512, head);

    // Asynchronous reset mid-frame while PDM is high and a word is pending.
    send(16'h8000);
    wait_frm_strt();
    send(16'h1000);
    check("prerst_pending", 32'(duty_rdy), 32'd0);
    run_cycles(300);
    n = 0;
    while (pdm !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    check("prerst_pdm_high", 32'(pdm), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pdm", 32'(pdm), 32'd0);
    check("rst_strt", 32'(frm_strt), 32'd0);
    check("rst_rdy", 32'(duty_rdy), 32'd1);
    check("rst_accum", 32'(dut.u_core.accum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst_strt", 32'(frm_strt), 32'd1);
    count_frame("postrst", 0, head);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
